// File: rtl/vram_scanout_pkg.sv
// Shared types and helpers for the scanout video RAM: scan FSM states,
// pixels-per-word arithmetic and the per-pixel masked write merge.
package vram_scanout_pkg;

    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_RUN,
        SCAN_DRAIN
    } scan_state_e;

    function automatic int ppw(input int bpp);
        return 16 / bpp;
    endfunction

    function automatic bit bpp_legal(input int bpp);
        return (bpp == 1) || (bpp == 2) || (bpp == 4) || (bpp == 8);
    endfunction

    // Bit b of the word belongs to pixel b/bpp; masked-off pixels keep the old value.
    function automatic logic [15:0] merge_word(input logic [15:0] old_w,
                                               input logic [15:0] new_w,
                                               input logic [15:0] pmask,
                                               input int          bpp);
        logic [15:0] r;
        r = old_w;
        for (int b = 0; b < 16; b++) begin
            if (pmask[b / bpp]) r[b] = new_w[b];
        end
        return r;
    endfunction

endpackage

// File: rtl/vram_word_fifo.sv
// Show-ahead synchronous FIFO of 16-bit words between the RAM fetch path
// and the pixel serializer; o_data is the head entry whenever not empty.
module vram_word_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       bus_clock,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [15:0]                i_data,
    output logic [15:0]                o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty,
    output logic                       o_full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (i_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({i_push, i_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge bus_clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge bus_clock) begin
        if (i_push) mem[wr_ptr_q] <= i_data;
    end

    assign o_data  = mem[rd_ptr_q];
    assign o_count = count_q;
    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/sub_bus_vram_scanout.sv
// Single-port video RAM shared between a masked CPU bus port and a scanout
// engine that prefetches words into a FIFO and streams them out as pixels.
module sub_bus_vram_scanout
    import vram_scanout_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int BPP        = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  bus_clock,
    input  logic                  reset,
    input  logic                  i_bus_req,
    input  logic                  i_bus_we,
    input  logic [ADDR_WIDTH-1:0] i_bus_addr,
    input  logic [15:0]           i_bus_data_write,
    input  logic [16/BPP-1:0]     i_bus_pmask,
    output logic                  o_bus_ready,
    output logic [15:0]           o_bus_data_read,
    input  logic                  i_scan_start,
    input  logic [ADDR_WIDTH-1:0] i_scan_base,
    input  logic [ADDR_WIDTH:0]   i_scan_words,
    output logic                  o_pix_valid,
    output logic [BPP-1:0]        o_pix_data,
    input  logic                  i_pix_ready,
    output logic                  o_scan_busy,
    output logic                  o_scan_done,
    output logic                  o_underrun
);
    localparam int PPW    = ppw(BPP);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W  = $clog2(PPW);
    localparam bit BPP_OK = bpp_legal(BPP);

    if (!BPP_OK) begin : g_bpp_check
        $error("sub_bus_vram_scanout: BPP must be 1, 2, 4 or 8");
    end

    logic [15:0]           mem [2**ADDR_WIDTH];
    logic [15:0]           rd_q;

    scan_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] scan_addr_q, scan_addr_d;
    logic [ADDR_WIDTH:0]   words_left_q, words_left_d;
    logic                  done_q, done_d;
    logic                  underrun_q, underrun_d;
    logic                  primed_q, primed_d;

    logic                  bus_phase_q, bus_phase_d;
    logic                  bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [15:0]           bus_wdata_q, bus_wdata_d;
    logic [PPW-1:0]        bus_pmask_q, bus_pmask_d;
    logic [15:0]           rdata_hold_q, rdata_hold_d;
    logic                  fetch_inflight_q, fetch_inflight_d;

    logic [15:0]           ser_word_q, ser_word_d;
    logic                  ser_valid_q, ser_valid_d;
    logic [IDX_W-1:0]      ser_idx_q, ser_idx_d;

    logic                  fetch_grant, bus_grant, fetch_room, below_half;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  pix_accept, pix_last, fifo_pop, pixels_left;
    logic [15:0]           fifo_dout;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty, fifo_full;

    vram_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .bus_clock (bus_clock),
        .reset     (reset),
        .i_push    (fetch_inflight_q),
        .i_pop     (fifo_pop),
        .i_data    (rd_q),
        .o_data    (fifo_dout),
        .o_count   (fifo_count),
        .o_empty   (fifo_empty),
        .o_full    (fifo_full)
    );

    // In-flight fetches already own a FIFO slot, so they count against free space.
    always_comb begin
        fetch_room  = !fifo_full &&
                      (({1'b0, fifo_count} + (CW+1)'(fetch_inflight_q)) < (CW+1)'(FIFO_DEPTH));
        below_half  = fifo_count < CW'(FIFO_DEPTH / 2);
        fetch_grant = !bus_phase_q && (state_q == SCAN_RUN) && (words_left_q != '0) &&
                      fetch_room && (!i_bus_req || below_half);
        bus_grant   = !bus_phase_q && !fetch_grant && i_bus_req;
        ram_addr    = fetch_grant ? scan_addr_q : i_bus_addr;
    end

    always_comb begin
        bus_phase_d      = bus_grant;
        fetch_inflight_d = fetch_grant;
        bus_we_d         = bus_grant ? i_bus_we         : bus_we_q;
        bus_addr_d       = bus_grant ? i_bus_addr       : bus_addr_q;
        bus_wdata_d      = bus_grant ? i_bus_data_write : bus_wdata_q;
        bus_pmask_d      = bus_grant ? i_bus_pmask      : bus_pmask_q;
        rdata_hold_d     = (bus_phase_q && !bus_we_q) ? rd_q : rdata_hold_q;
    end

    // RAM contents are not reset; the write half of a bus access lands in its second cycle.
    always_ff @(posedge bus_clock) begin
        if (fetch_grant || bus_grant) rd_q <= mem[ram_addr];
        if (bus_phase_q && bus_we_q)
            mem[bus_addr_q] <= merge_word(rd_q, bus_wdata_q, 16'(bus_pmask_q), BPP);
    end

    always_comb begin
        pix_accept  = ser_valid_q && i_pix_ready;
        pix_last    = (ser_idx_q == IDX_W'(PPW - 1));
        fifo_pop    = !fifo_empty && (!ser_valid_q || (pix_accept && pix_last));
        ser_word_d  = ser_word_q;
        ser_valid_d = ser_valid_q;
        ser_idx_d   = ser_idx_q;
        if (fifo_pop) begin
            ser_word_d  = fifo_dout;
            ser_valid_d = 1'b1;
            ser_idx_d   = '0;
        end else if (pix_accept) begin
            ser_word_d  = ser_word_q >> BPP;
            ser_idx_d   = ser_idx_q + IDX_W'(1);
            if (pix_last) ser_valid_d = 1'b0;
        end
    end

    // Starvation only counts once the stream has produced its first pixel;
    // the prefetch latency at the start of a run is expected.
    always_comb begin
        state_d      = state_q;
        scan_addr_d  = scan_addr_q;
        words_left_d = words_left_q;
        done_d       = 1'b0;
        underrun_d   = underrun_q;
        primed_d     = primed_q;
        pixels_left  = (words_left_q != '0) || fetch_inflight_q || !fifo_empty;
        case (state_q)
            SCAN_IDLE: begin
                if (i_scan_start) begin
                    scan_addr_d  = i_scan_base;
                    words_left_d = i_scan_words;
                    if (i_scan_words == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = SCAN_RUN;
                        underrun_d = 1'b0;
                        primed_d   = 1'b0;
                    end
                end
            end
            SCAN_RUN: begin
                if (fetch_grant) begin
                    scan_addr_d  = scan_addr_q + ADDR_WIDTH'(1);
                    words_left_d = words_left_q - (ADDR_WIDTH+1)'(1);
                end
                if (words_left_d == '0) state_d = SCAN_DRAIN;
            end
            SCAN_DRAIN: begin
                if (fifo_empty && !fetch_inflight_q && !ser_valid_q) begin
                    done_d  = 1'b1;
                    state_d = SCAN_IDLE;
                end
            end
            default: state_d = SCAN_IDLE;
        endcase
        if (state_q != SCAN_IDLE) begin
            if (ser_valid_q) primed_d = 1'b1;
            if (primed_q && i_pix_ready && !ser_valid_q && pixels_left) underrun_d = 1'b1;
        end
    end

    always_ff @(posedge bus_clock or posedge reset) begin
        if (reset) begin
            state_q          <= SCAN_IDLE;
            scan_addr_q      <= '0;
            words_left_q     <= '0;
            done_q           <= 1'b0;
            underrun_q       <= 1'b0;
            primed_q         <= 1'b0;
            bus_phase_q      <= 1'b0;
            bus_we_q         <= 1'b0;
            bus_addr_q       <= '0;
            bus_wdata_q      <= '0;
            bus_pmask_q      <= '0;
            rdata_hold_q     <= '0;
            fetch_inflight_q <= 1'b0;
            ser_word_q       <= '0;
            ser_valid_q      <= 1'b0;
            ser_idx_q        <= '0;
        end else begin
            state_q          <= state_d;
            scan_addr_q      <= scan_addr_d;
            words_left_q     <= words_left_d;
            done_q           <= done_d;
            underrun_q       <= underrun_d;
            primed_q         <= primed_d;
            bus_phase_q      <= bus_phase_d;
            bus_we_q         <= bus_we_d;
            bus_addr_q       <= bus_addr_d;
            bus_wdata_q      <= bus_wdata_d;
            bus_pmask_q      <= bus_pmask_d;
            rdata_hold_q     <= rdata_hold_d;
            fetch_inflight_q <= fetch_inflight_d;
            ser_word_q       <= ser_word_d;
            ser_valid_q      <= ser_valid_d;
            ser_idx_q        <= ser_idx_d;
        end
    end

    assign o_bus_ready     = bus_phase_q;
    assign o_bus_data_read = (bus_phase_q && !bus_we_q) ? rd_q : rdata_hold_q;
    assign o_pix_valid     = ser_valid_q;
    assign o_pix_data      = ser_word_q[BPP-1:0];
    assign o_scan_busy     = (state_q != SCAN_IDLE);
    assign o_scan_done     = done_q;
    assign o_underrun      = underrun_q;

endmodule

// File: tb/tb_sub_bus_vram_scanout.sv
// Directed bench for sub_bus_vram_scanout: masked bus writes, scan streaming,
// address wrap, bus/scan contention, FIFO back-pressure, reset and start corner cases.
module tb_sub_bus_vram_scanout;

    logic        bus_clock = 1'b0;
    logic        reset;
    logic        i_bus_req;
    logic        i_bus_we;
    logic [13:0] i_bus_addr;
    logic [15:0] i_bus_data_write;
    logic [3:0]  i_bus_pmask;
    logic        o_bus_ready;
    logic [15:0] o_bus_data_read;
    logic        i_scan_start;
    logic [13:0] i_scan_base;
    logic [14:0] i_scan_words;
    logic        o_pix_valid;
    logic [3:0]  o_pix_data;
    logic        i_pix_ready;
    logic        o_scan_busy;
    logic        o_scan_done;
    logic        o_underrun;

    int          vectors    = 0;
    int          miscompares = 0;

    logic [3:0]  cap_pix [64];
    int          cap_cyc [64];
    int          cap_n, done_cnt, ready_cnt, rd_bad, max_cnt;
    logic        under_seen, busy_at_done;
    logic [15:0] run_words [$];
    logic [15:0] word_tab [12];
    logic [15:0] rdata;
    int          lat;

    sub_bus_vram_scanout #(.ADDR_WIDTH(14), .BPP(4), .FIFO_DEPTH(8)) dut (
        .bus_clock        (bus_clock),
        .reset            (reset),
        .i_bus_req        (i_bus_req),
        .i_bus_we         (i_bus_we),
        .i_bus_addr       (i_bus_addr),
        .i_bus_data_write (i_bus_data_write),
        .i_bus_pmask      (i_bus_pmask),
        .o_bus_ready      (o_bus_ready),
        .o_bus_data_read  (o_bus_data_read),
        .i_scan_start     (i_scan_start),
        .i_scan_base      (i_scan_base),
        .i_scan_words     (i_scan_words),
        .o_pix_valid      (o_pix_valid),
        .o_pix_data       (o_pix_data),
        .i_pix_ready      (i_pix_ready),
        .o_scan_busy      (o_scan_busy),
        .o_scan_done      (o_scan_done),
        .o_underrun       (o_underrun)
    );

    always #5 bus_clock = ~bus_clock;

    task automatic tick();
        @(posedge bus_clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One bus transaction; lat = cycles from request to ready, -1 on timeout.
    task automatic applyStimulus(input logic we, input logic [13:0] addr, input logic [15:0] wdata,
                                 input logic [3:0] pmask, output logic [15:0] rd, output int lt);
        logic got;
        got = 1'b0;
        i_bus_req = 1'b1;
        i_bus_we = we;
        i_bus_addr = addr;
        i_bus_data_write = wdata;
        i_bus_pmask = pmask;
        lt = 0;
        rd = '0;
        for (int k = 0; k < 20; k++) begin
            tick();
            lt++;
            if (o_bus_ready) begin
                rd = o_bus_data_read;
                got = 1'b1;
                break;
            end
        end
        i_bus_req = 1'b0;
        i_bus_we = 1'b0;
        if (!got) lt = -1;
    endtask

    task automatic startScan(input logic [13:0] base, input logic [14:0] words);
        i_scan_base = base;
        i_scan_words = words;
        i_scan_start = 1'b1;
        tick();
        i_scan_start = 1'b0;
    endtask

    // Observe the current cycle, then advance; stops at the done pulse.
    task automatic runCapture(input int budget, input logic [15:0] bus_exp);
        cap_n = 0; done_cnt = 0; ready_cnt = 0; rd_bad = 0; max_cnt = 0;
        under_seen = 1'b0; busy_at_done = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
            if (o_underrun) under_seen = 1'b1;
            if (o_bus_ready) begin
                ready_cnt++;
                if (o_bus_data_read !== bus_exp) rd_bad++;
            end
            if (o_pix_valid && i_pix_ready && cap_n < 64) begin
                cap_pix[cap_n] = o_pix_data;
                cap_cyc[cap_n] = c;
                cap_n++;
            end
            if (o_scan_done) begin
                done_cnt++;
                busy_at_done = o_scan_busy;
                break;
            end
            tick();
        end
    endtask

    task automatic checkRun(input string tag);
        int   n_exp;
        logic gap;
        logic [15:0] w;
        n_exp = run_words.size() * 4;
        checkOutput($sformatf("%s_count", tag), cap_n, n_exp);
        gap = 1'b0;
        for (int i = 0; i < cap_n && i < n_exp; i++) begin
            w = run_words[i / 4];
            checkOutput($sformatf("%s_pix%0d", tag, i), cap_pix[i], w[(i % 4) * 4 +: 4]);
            if (i > 0 && cap_cyc[i] != cap_cyc[i-1] + 1) gap = 1'b1;
        end
        checkOutput($sformatf("%s_no_bubble", tag), gap, 1'b0);
        checkOutput($sformatf("%s_done", tag), done_cnt, 1);
        checkOutput($sformatf("%s_busy_at_done", tag), busy_at_done, 1'b0);
        checkOutput($sformatf("%s_underrun", tag), under_seen, 1'b0);
        tick();
        checkOutput($sformatf("%s_done_one_cycle", tag), o_scan_done, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        i_bus_req = 1'b0; i_bus_we = 1'b0; i_bus_addr = '0; i_bus_data_write = '0; i_bus_pmask = '0;
        i_scan_start = 1'b0; i_scan_base = '0; i_scan_words = '0; i_pix_ready = 1'b0;
        word_tab = '{16'h4321, 16'h8765, 16'hCBA9, 16'h3333, 16'h4444, 16'h5555,
                     16'h6666, 16'h7777, 16'h8888, 16'h9999, 16'hAAAA, 16'hBBBB};
        tick(); tick();
        checkOutput("rst_ready", o_bus_ready, 1'b0);
        checkOutput("rst_rdata", o_bus_data_read, 16'h0000);
        checkOutput("rst_pix_valid", o_pix_valid, 1'b0);
        checkOutput("rst_busy", o_scan_busy, 1'b0);
        checkOutput("rst_done", o_scan_done, 1'b0);
        checkOutput("rst_underrun", o_underrun, 1'b0);
        reset = 1'b0;
        tick();

        $display("[TB] bus full write and readback");
        applyStimulus(1'b1, 14'h0010, 16'hCBA9, 4'b1111, rdata, lat);
        checkOutput("wr_latency", lat, 1);
        applyStimulus(1'b0, 14'h0010, 16'h0000, 4'b0000, rdata, lat);
        checkOutput("rd_full", rdata, 16'hCBA9);

        $display("[TB] masked writes");
        applyStimulus(1'b1, 14'h0020, 16'h4321, 4'b1111, rdata, lat);
        checkOutput("wr_keeps_rdata", rdata, 16'hCBA9);
        applyStimulus(1'b1, 14'h0020, 16'hFFFF, 4'b0101, rdata, lat);
        applyStimulus(1'b0, 14'h0020, 16'h0000, 4'b0000, rdata, lat);
        checkOutput("rd_masked", rdata, 16'h4F2F);
        applyStimulus(1'b1, 14'h0020, 16'h0000, 4'b0000, rdata, lat);
        checkOutput("zero_mask_ready", lat != -1, 1'b1);
        applyStimulus(1'b0, 14'h0020, 16'h0000, 4'b0000, rdata, lat);
        checkOutput("rd_zero_mask", rdata, 16'h4F2F);

        for (int k = 0; k < 12; k++)
            applyStimulus(1'b1, 14'(k), word_tab[k], 4'b1111, rdata, lat);
        applyStimulus(1'b1, 14'h3FFF, 16'hFEDC, 4'b1111, rdata, lat);
        tick();

        $display("[TB] three-word scan");
        i_pix_ready = 1'b1;
        startScan(14'h0000, 15'd3);
        checkOutput("scan1_busy", o_scan_busy, 1'b1);
        runCapture(100, 16'h0000);
        run_words.delete();
        for (int k = 0; k < 3; k++) run_words.push_back(word_tab[k]);
        checkRun("scan1");

        $display("[TB] address wrap");
        startScan(14'h3FFF, 15'd2);
        runCapture(100, 16'h0000);
        run_words.delete();
        run_words.push_back(16'hFEDC);
        run_words.push_back(16'h4321);
        checkRun("wrap");

        $display("[TB] scan with continuous bus requests");
        i_bus_req = 1'b1; i_bus_we = 1'b0; i_bus_addr = 14'h0010; i_bus_pmask = 4'b0000;
        tick();
        startScan(14'h0000, 15'd12);
        runCapture(300, 16'hCBA9);
        i_bus_req = 1'b0;
        run_words.delete();
        for (int k = 0; k < 12; k++) run_words.push_back(word_tab[k]);
        checkRun("contend");
        checkOutput("contend_bus_progress", ready_cnt > 0, 1'b1);
        checkOutput("contend_bus_data", rd_bad, 0);
        tick(); tick();

        $display("[TB] back-pressure until FIFO full");
        i_pix_ready = 1'b0;
        startScan(14'h0000, 15'd12);
        max_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
        end
        checkOutput("full_max_occupancy", max_cnt, 8);
        checkOutput("full_pix_held_valid", o_pix_valid, 1'b1);
        checkOutput("full_pix_held_data", o_pix_data, 4'h1);
        applyStimulus(1'b1, 14'h0030, 16'h5A5A, 4'b1111, rdata, lat);
        checkOutput("full_bus_write_done", lat != -1, 1'b1);
        applyStimulus(1'b0, 14'h0030, 16'h0000, 4'b0000, rdata, lat);
        checkOutput("full_bus_read", rdata, 16'h5A5A);
        checkOutput("full_pix_still_held", o_pix_data, 4'h1);
        i_pix_ready = 1'b1;
        runCapture(300, 16'h0000);
        checkOutput("drain_occupancy_bound", max_cnt <= 8, 1'b1);
        checkRun("full");

        $display("[TB] reset during a run");
        i_pix_ready = 1'b0;
        startScan(14'h0000, 15'd12);
        for (int c = 0; c < 5; c++) tick();
        #3 reset = 1'b1;
        #1;
        checkOutput("amid_busy", o_scan_busy, 1'b0);
        checkOutput("amid_pix_valid", o_pix_valid, 1'b0);
        checkOutput("amid_pix_data", o_pix_data, 4'h0);
        checkOutput("amid_ready", o_bus_ready, 1'b0);
        checkOutput("amid_rdata", o_bus_data_read, 16'h0000);
        checkOutput("amid_done", o_scan_done, 1'b0);
        checkOutput("amid_underrun", o_underrun, 1'b0);
        checkOutput("amid_fifo_empty", dut.fifo_empty, 1'b1);
        tick(); tick();
        reset = 1'b0;
        tick();

        $display("[TB] zero-length scan");
        startScan(14'h0005, 15'd0);
        checkOutput("zero_done", o_scan_done, 1'b1);
        checkOutput("zero_busy", o_scan_busy, 1'b0);
        tick();
        checkOutput("zero_done_once", o_scan_done, 1'b0);
        checkOutput("zero_busy_after", o_scan_busy, 1'b0);

        $display("[TB] start while busy is ignored");
        i_pix_ready = 1'b1;
        startScan(14'h0000, 15'd3);
        i_scan_base = 14'h3FFF;
        i_scan_words = 15'd2;
        i_scan_start = 1'b1;
        checkOutput("restart_busy", o_scan_busy, 1'b1);
        tick();
        i_scan_start = 1'b0;
        runCapture(100, 16'h0000);
        run_words.delete();
        for (int k = 0; k < 3; k++) run_words.push_back(word_tab[k]);
        checkRun("restart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
